// File: rtl/disp_mux_ctrl.sv
// Time-multiplexed N-digit 7-segment driver: shadow-registered digit data,
// one digit per refresh slot, blank interval, leading-zero suppression, polarity.
module disp_mux_ctrl #(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     en_in,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [N_DIGITS-1:0]     an_out
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]    IDX_MAX   = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_POL   = {7{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] AN_POL    = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic [N_DIGITS-1:0]   en_q, en_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_out_q, dp_out_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic [N_DIGITS-1:0]   lz_blank;
  logic                  lead;
  logic [3:0]            nib;
  logic [3:0]            cur_nib;
  logic                  cur_en;
  logic                  lit;
  logic [6:0]            seg_act;
  logic [N_DIGITS-1:0]   an_act;
  logic                  dp_act;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'b1111110;
      4'h1: seg_decode = 7'b0110000;
      4'h2: seg_decode = 7'b1101101;
      4'h3: seg_decode = 7'b1111001;
      4'h4: seg_decode = 7'b0110011;
      4'h5: seg_decode = 7'b1011011;
      4'h6: seg_decode = 7'b1011111;
      4'h7: seg_decode = 7'b1110000;
      4'h8: seg_decode = 7'b1111111;
      4'h9: seg_decode = 7'b1110011;
      4'hA: seg_decode = 7'b1110111;
      4'hB: seg_decode = 7'b0011111;
      4'hC: seg_decode = 7'b1001110;
      4'hD: seg_decode = 7'b0111101;
      4'hE: seg_decode = 7'b1001111;
      default: seg_decode = 7'b1000111;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    digits_d = load ? digits_in : digits_q;
    dp_d     = load ? dp_in     : dp_q;
    en_d     = load ? en_in     : en_q;
  end

  // Scan from the most significant digit; only an enabled non-zero digit ends the leading run.
  always_comb begin
    lead     = 1'b1;
    nib      = 4'h0;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      nib         = digits_q[4*i +: 4];
      lz_blank[i] = lz_suppress && (i > 0) && (nib == 4'h0) && lead;
      if (en_q[i] && (nib != 4'h0)) lead = 1'b0;
    end
  end

  always_comb begin
    cur_nib = digits_q[{idx_q, 2'b00} +: 4];
    cur_en  = en_q[idx_q];
    lit     = (cnt_q >= BLANK_END);
    an_act  = '0;
    seg_act = '0;
    dp_act  = 1'b0;
    if (lit) begin
      an_act[idx_q] = 1'b1;
      dp_act        = dp_q[idx_q] & cur_en;
      if (cur_en && !lz_blank[idx_q]) seg_act = seg_decode(cur_nib);
    end
    seg_d    = seg_act ^ SEG_POL;
    dp_out_d = dp_act ^ SEG_ACTIVE_LOW;
    an_d     = an_act ^ AN_POL;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the shadow registers are a handful of flops, not a RAM, so they take the async reset too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      digits_q <= '0;
      dp_q     <= '0;
      en_q     <= '0;
      seg_q    <= SEG_POL;
      dp_out_q <= SEG_ACTIVE_LOW;
      an_q     <= AN_POL;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      en_q     <= en_d;
      seg_q    <= seg_d;
      dp_out_q <= dp_out_d;
      an_q     <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign dp_out  = dp_out_q;
  assign an_out  = an_q;

endmodule
